// File: rtl/i2s_pkg.sv
// Shared I2S framing constants and slot-position helpers for the transmit path.
package i2s_pkg;

  localparam int unsigned I2S_SLOT_BITS  = 32;
  localparam int unsigned I2S_FRAME_BITS = 64;
  localparam int unsigned BIT_CNT_W      = $clog2(I2S_FRAME_BITS);

  typedef logic [BIT_CNT_W-1:0] bit_cnt_t;

  // lrclk is high one bit before the right-slot MSB through the bit before the left MSB
  localparam bit_cnt_t LR_RIGHT_FIRST = bit_cnt_t'(I2S_SLOT_BITS - 1);
  localparam bit_cnt_t LR_RIGHT_LAST  = bit_cnt_t'(I2S_FRAME_BITS - 2);
  localparam bit_cnt_t BIT_CNT_IDLE   = bit_cnt_t'(I2S_FRAME_BITS - 1);
  localparam bit_cnt_t SLOT_L_FETCH   = bit_cnt_t'(0);
  localparam bit_cnt_t SLOT_R_FETCH   = bit_cnt_t'(I2S_SLOT_BITS);

  function automatic logic lrclk_for(bit_cnt_t b);
    return (b >= LR_RIGHT_FIRST) && (b <= LR_RIGHT_LAST);
  endfunction

  function automatic logic is_fetch(bit_cnt_t b);
    return (b == SLOT_L_FETCH) || (b == SLOT_R_FETCH);
  endfunction

endpackage

// File: rtl/i2s_tx_fifo.sv
// Single-clock first-word-fall-through FIFO; head is valid whenever empty is low.
module i2s_tx_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   free_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= din;
  end

  assign head       = mem[rd_ptr_q];
  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);
  assign free_count = CW'(DEPTH) - count_q;

endmodule

// File: rtl/i2s_transmitter.sv
// I2S Philips-format master transmitter: write port -> FWFT FIFO -> bclk/lrclk/sdata.
// Optional I2S_TX_ID_FILTER_EN: keep only words tagged with this lane's ID and MSB-align the payload.
module i2s_transmitter
  import i2s_pkg::*;
#(
  parameter int unsigned FIFO_DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH      = 256,
  parameter int unsigned BULK_OF_DATA    = 87,
  parameter int unsigned BCLK_DIV        = 8,
  parameter int unsigned ID              = 0,
  parameter int unsigned ID_WIDTH        = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       wen,
  input  logic [FIFO_DATA_WIDTH-1:0] wdata,
  output logic                       w_ready,
  output logic                       bclk,
  output logic                       lrclk,
  output logic                       sdata,
  output logic                       error_full,
  output logic                       error_empty
);

  localparam int unsigned W  = FIFO_DATA_WIDTH;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned DW = $clog2(BCLK_DIV);

  logic [DW-1:0] div_cnt_q;
  bit_cnt_t      bit_cnt_q, bit_cnt_nxt;
  logic [W-1:0]  shreg_q;
  logic          bclk_q, lrclk_q, sdata_q, w_ready_q, error_full_q, error_empty_q;

  logic          wr_accept, push, pop, fifo_full, fifo_empty;
  logic [W-1:0]  fifo_din, fifo_head;
  logic [CW-1:0] free_count, free_nxt;
  logic          div_wrap, bclk_fall, slot_fetch;

`ifdef I2S_TX_ID_FILTER_EN
  assign wr_accept = wen && (wdata[W-1 -: ID_WIDTH] == ID_WIDTH'(ID));
  assign fifo_din  = {wdata[W-ID_WIDTH-1:0], {ID_WIDTH{1'b0}}};
`else
  logic unused_id_cfg;
  assign unused_id_cfg = (ID == ID_WIDTH);
  assign wr_accept     = wen;
  assign fifo_din      = wdata;
`endif

  assign div_wrap    = (div_cnt_q == DW'(BCLK_DIV - 1));
  assign bclk_fall   = enable && div_wrap && bclk_q;
  assign bit_cnt_nxt = bit_cnt_q + bit_cnt_t'(1);
  assign slot_fetch  = bclk_fall && is_fetch(bit_cnt_nxt);
  assign pop         = slot_fetch && !fifo_empty;
  // A pop in the same cycle frees the slot a full-FIFO write needs
  assign push        = wr_accept && (!fifo_full || pop);
  assign free_nxt    = free_count + CW'(pop) - CW'(push);

  i2s_tx_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .din        (fifo_din),
    .pop        (pop),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .free_count (free_count)
  );

  // shreg holds the bits still to be sent; the current bit already sits in sdata
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q     <= '0;
      bit_cnt_q     <= BIT_CNT_IDLE;
      shreg_q       <= '0;
      bclk_q        <= 1'b0;
      lrclk_q       <= 1'b0;
      sdata_q       <= 1'b0;
      w_ready_q     <= 1'b1;
      error_full_q  <= 1'b0;
      error_empty_q <= 1'b0;
    end else begin
      w_ready_q <= (free_nxt >= CW'(BULK_OF_DATA));
      if (wr_accept && fifo_full && !pop) error_full_q <= 1'b1;

      if (!enable) begin
        div_cnt_q <= '0;
        bit_cnt_q <= BIT_CNT_IDLE;
        shreg_q   <= '0;
        bclk_q    <= 1'b0;
        lrclk_q   <= 1'b0;
        sdata_q   <= 1'b0;
      end else begin
        if (div_wrap) begin
          div_cnt_q <= '0;
          bclk_q    <= ~bclk_q;
        end else begin
          div_cnt_q <= div_cnt_q + DW'(1);
        end

        if (bclk_fall) begin
          bit_cnt_q <= bit_cnt_nxt;
          lrclk_q   <= lrclk_for(bit_cnt_nxt);
          if (slot_fetch) begin
            if (fifo_empty) begin
              shreg_q       <= '0;
              sdata_q       <= 1'b0;
              error_empty_q <= 1'b1;
            end else begin
              shreg_q <= {fifo_head[W-2:0], 1'b0};
              sdata_q <= fifo_head[W-1];
            end
          end else begin
            shreg_q <= {shreg_q[W-2:0], 1'b0};
            sdata_q <= shreg_q[W-1];
          end
        end
      end
    end
  end

  assign w_ready     = w_ready_q;
  assign bclk        = bclk_q;
  assign lrclk       = lrclk_q;
  assign sdata       = sdata_q;
  assign error_full  = error_full_q;
  assign error_empty = error_empty_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Self-checking bench for i2s_transmitter: serial stream decoded per bclk falling edge and
// compared slot-by-slot against a queue model of the words the FIFO must deliver.
module tb_i2s_transmitter;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned BULK  = 87;
  localparam int unsigned DIV   = 2;
  localparam int unsigned TB_ID = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        wen = 1'b0;
  logic [31:0] wdata = '0;
  logic        w_ready, bclk, lrclk, sdata, error_full, error_empty;

  always #5 clk = ~clk;

  i2s_transmitter #(
    .FIFO_DATA_WIDTH (32),
    .FIFO_DEPTH      (DEPTH),
    .BULK_OF_DATA    (BULK),
    .BCLK_DIV        (DIV),
    .ID              (TB_ID),
    .ID_WIDTH        (5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .wen         (wen),
    .wdata       (wdata),
    .w_ready     (w_ready),
    .bclk        (bclk),
    .lrclk       (lrclk),
    .sdata       (sdata),
    .error_full  (error_full),
    .error_empty (error_empty)
  );

  int checks = 0;
  int errors = 0;

  logic        sd_q[$];
  logic        lr_q[$];
  int          fall_cyc[$];
  logic [31:0] model_q[$];

  typedef struct {
    logic [31:0] w;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Lane filtering as seen from the outside: which words get in and what they look like
  function automatic logic accepted(input logic [31:0] w);
`ifdef I2S_TX_ID_FILTER_EN
    return w[31:27] == 5'(TB_ID);
`else
    return (w == w);
`endif
  endfunction

  function automatic logic [31:0] stored(input logic [31:0] w);
`ifdef I2S_TX_ID_FILTER_EN
    return {w[26:0], 5'b0};
`else
    return w;
`endif
  endfunction

  function automatic logic [31:0] tag(input logic [31:0] w);
`ifdef I2S_TX_ID_FILTER_EN
    return {5'(TB_ID), w[26:0]};
`else
    return w;
`endif
  endfunction

  task automatic do_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    wen    = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    model_q.delete();
  endtask

  // Writes only while serialisation is idle, so the model's full check is exact
  task automatic write_word(input logic [31:0] w);
    wen   = 1'b1;
    wdata = w;
    step();
    wen = 1'b0;
    if (accepted(w) && model_q.size() < DEPTH) model_q.push_back(stored(w));
  endtask

  task automatic collect(input int nbits);
    int   n = 0;
    int   cyc = 0;
    int   limit = nbits * 2 * DIV + 8 * DIV + 16;
    logic prev = bclk;
    sd_q.delete();
    lr_q.delete();
    fall_cyc.delete();
    while (n < nbits && cyc < limit) begin
      step();
      cyc++;
      if (prev && !bclk) begin
        sd_q.push_back(sdata);
        lr_q.push_back(lrclk);
        fall_cyc.push_back(cyc);
        n++;
      end
      prev = bclk;
    end
    chk("collect_bits", n, nbits);
  endtask

  function automatic logic [31:0] slot_word(input int s);
    logic [31:0] w = '0;
    for (int j = 0; j < 32; j++) begin
      if (32 * s + j < sd_q.size()) w = {w[30:0], sd_q[32*s+j]};
      else w = {w[30:0], 1'b0};
    end
    return w;
  endfunction

  function automatic int lr_errs(input int nbits);
    int e = 0;
    for (int i = 0; i < nbits && i < lr_q.size(); i++) begin
      if (lr_q[i] !== ((i % 64) >= 31 && (i % 64) <= 62)) e++;
    end
    return e;
  endfunction

  task automatic check_slots(input string name, input int nslots);
    logic [31:0] exp;
    for (int s = 0; s < nslots; s++) begin
      exp = (model_q.size() > 0) ? model_q.pop_front() : 32'h0;
      chk($sformatf("%s_slot%0d", name, s), slot_word(s), exp);
    end
    chk($sformatf("%s_lrclk", name), lr_errs(nslots * 32), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[6];
    logic [31:0] w;
    int          n, ones, per_err;

    vecs[0] = '{tag(32'hA5A5_A5A5), stored(tag(32'hA5A5_A5A5))};
    vecs[1] = '{tag(32'h5A5A_5A5A), stored(tag(32'h5A5A_5A5A))};
    vecs[2] = '{tag(32'h0000_0000), stored(tag(32'h0000_0000))};
    vecs[3] = '{tag(32'hFFFF_FFFF), stored(tag(32'hFFFF_FFFF))};
    vecs[4] = '{tag(32'h8000_0001), stored(tag(32'h8000_0001))};
    vecs[5] = '{tag(32'h1234_5678), stored(tag(32'h1234_5678))};

    // Reset values, then asynchronous reset in the middle of a run
    do_reset();
    chk("rst_outputs", {27'b0, bclk, lrclk, sdata, error_full, error_empty}, 32'h0);
    chk("rst_w_ready", w_ready, 1);
    write_word(tag(32'h1111_1111));
    write_word(tag(32'h2222_2222));
    enable = 1'b1;
    repeat (3 * 64 * 2 * DIV + 8) step();
    chk("run_error_empty", error_empty, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_outputs", {27'b0, bclk, lrclk, sdata, error_full, error_empty}, 32'h0);
    step();
    enable = 1'b0;
    rst_n  = 1'b1;
    step();
    chk("post_rst_w_ready", w_ready, 1);

    // Table of words: latency, bclk period, bit order and lrclk alignment
    do_reset();
    for (int i = 0; i < 6; i++) write_word(vecs[i].w);
    model_q.delete();
    enable = 1'b1;
    collect(6 * 32);
    chk("first_fall_latency", fall_cyc.size() > 0 ? fall_cyc[0] : -1, 2 * DIV);
    per_err = 0;
    for (int i = 1; i < fall_cyc.size(); i++) if (fall_cyc[i] - fall_cyc[i-1] != 2 * DIV) per_err++;
    chk("bclk_period", per_err, 0);
    for (int i = 0; i < 6; i++) chk($sformatf("table_slot%0d", i), slot_word(i), vecs[i].exp);
    chk("table_lrclk", lr_errs(6 * 32), 0);
    chk("table_no_error_empty", error_empty, 0);

    // Empty FIFO: underrun at the first fetch, framing continues
    do_reset();
    enable = 1'b1;
    repeat (2 * DIV - 1) step();
    chk("empty_before_fetch", error_empty, 0);
    step();
    chk("empty_at_fetch", error_empty, 1);
    chk("empty_sdata", sdata, 0);
    enable = 1'b0;
    step();
    enable = 1'b1;
    collect(128);
    ones = 0;
    foreach (sd_q[i]) if (sd_q[i]) ones++;
    chk("empty_sdata_zero", ones, 0);
    chk("empty_lrclk", lr_errs(128), 0);

    // Fill to overflow while idle, then drain everything
    do_reset();
    for (int k = 1; k <= 257; k++) begin
      write_word(tag($urandom));
      chk($sformatf("w_ready_after_%0d", k), w_ready, (DEPTH - model_q.size()) >= BULK);
      if (k >= 256) chk($sformatf("error_full_after_%0d", k), error_full, k > 256);
    end
    enable = 1'b1;
    collect(257 * 32);
    check_slots("drain", 257);
    chk("drain_error_empty", error_empty, 1);
    chk("drain_w_ready", w_ready, 1);

    // Disable mid left slot: outputs idle next cycle, partial word is not replayed
    do_reset();
    w = tag($urandom | 32'h0020_0000);
    write_word(w);
    write_word(tag($urandom));
    write_word(tag($urandom));
    enable = 1'b1;
    collect(11);
    chk("partial_bits", {21'b0, sd_q[0], sd_q[1], sd_q[2], sd_q[3], sd_q[4], sd_q[5], sd_q[6],
                         sd_q[7], sd_q[8], sd_q[9], sd_q[10]}, {21'b0, model_q[0][31:21]});
    repeat (DIV) step();
    enable = 1'b0;
    step();
    chk("disable_idle", {29'b0, bclk, lrclk, sdata}, 32'h0);
    step();
    void'(model_q.pop_front());
    enable = 1'b1;
    collect(64);
    check_slots("resume", 2);
    chk("resume_no_error_empty", error_empty, 0);

    // Random burst against the queue model, including trailing underrun slots
    do_reset();
    n = $urandom_range(2, 20);
    for (int k = 0; k < n; k++) write_word(tag($urandom));
    enable = 1'b1;
    collect((n + 2) * 32);
    check_slots("random", n + 2);
    chk("random_error_empty", error_empty, 1);
    chk("random_error_full", error_full, 0);

`ifdef I2S_TX_ID_FILTER_EN
    do_reset();
    write_word(32'h1800_0001);
    write_word(32'h2000_0002);
    enable = 1'b1;
    collect(32);
    chk("filter_word", slot_word(0), 32'h0000_0020);
    chk("filter_flags", {30'b0, error_full, error_empty}, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
